// File: rtl/serializer_pkg.sv
// Shared types, TMDS control-period words and sizing helpers for the N-channel serializer.
package serializer_pkg;

   typedef logic [9:0] lane_word_t;

   // TMDS control-period symbols for {c1,c0} = 00, 01, 10, 11
   localparam lane_word_t TMDS_CTRL_00 = 10'h354;
   localparam lane_word_t TMDS_CTRL_01 = 10'h0AB;
   localparam lane_word_t TMDS_CTRL_10 = 10'h154;
   localparam lane_word_t TMDS_CTRL_11 = 10'h2AB;

   function automatic int slots(input int word_w, input int bits_per_cycle);
      return word_w / bits_per_cycle;
   endfunction

endpackage

// File: rtl/serializer_lane.sv
// One serializer lane: W-bit shifter feeding a registered B-bit output, LSB first on the wire.
module serializer_lane #(
   parameter int                    WORD_WIDTH     = 10,
   parameter int                    BITS_PER_CYCLE = 2,
   parameter logic [WORD_WIDTH-1:0] RESET_WORD     = '0
) (
   input  logic                      clk_pixel_x5,
   input  logic                      reset,
   input  logic                      load,
   input  logic [WORD_WIDTH-1:0]     load_word,
   output logic [BITS_PER_CYCLE-1:0] out_bits
);

   logic [WORD_WIDTH-1:0]     shift_p0;
   logic [BITS_PER_CYCLE-1:0] bits_p1;

   // p0: shifter, p1: output register toward the pin primitive
   always_ff @(posedge clk_pixel_x5) begin
      if (reset) begin
         shift_p0 <= RESET_WORD;
         bits_p1  <= '0;
      end else begin
         if (load)
            shift_p0 <= load_word;
         else
            shift_p0 <= shift_p0 >> BITS_PER_CYCLE;
         bits_p1 <= shift_p0[BITS_PER_CYCLE-1:0];
      end
   end

   assign out_bits = bits_p1;

endmodule

// File: rtl/serializer_nch.sv
// N-channel parallel-to-serial engine with valid/ready hold register, idle fill and underflow flag.
// Optional pixel-clock lane on out_clock_bits when SERIALIZER_NCH_CLOCK_LANE_EN is defined.
module serializer_nch
   import serializer_pkg::*;
#(
   parameter int                    NUM_CHANNELS   = 3,
   parameter int                    WORD_WIDTH     = 10,
   parameter int                    BITS_PER_CYCLE = 2,
   parameter logic [WORD_WIDTH-1:0] IDLE_WORD      = WORD_WIDTH'(TMDS_CTRL_00)
) (
   input  logic                                   clk_pixel_x5,
   input  logic                                   reset,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [NUM_CHANNELS*WORD_WIDTH-1:0]     in_data,
   output logic [NUM_CHANNELS*BITS_PER_CYCLE-1:0] out_bits,
   output logic                                   out_word_start,
`ifdef SERIALIZER_NCH_CLOCK_LANE_EN
   output logic [BITS_PER_CYCLE-1:0]              out_clock_bits,
`endif
   output logic                                   underflow,
   input  logic                                   underflow_clear
);

   localparam int SLOTS  = slots(WORD_WIDTH, BITS_PER_CYCLE);
   localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);

   if ((WORD_WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_width
      $error("serializer_nch: WORD_WIDTH must be a multiple of BITS_PER_CYCLE");
   end

   logic [SLOT_W-1:0]                  slot_p0;
   logic                               hold_vld_p0;
   logic [NUM_CHANNELS*WORD_WIDTH-1:0] hold_p0;
   logic                               armed_p0;
   logic                               underflow_p0;
   logic                               word_start_p1;
   logic                               last_slot;
   logic                               xfer;

   assign last_slot = (slot_p0 == SLOT_LAST);
   assign in_ready  = !hold_vld_p0 || last_slot;
   assign xfer      = in_valid && in_ready;

   // p0: slot counter, handshake and underflow control
   always_ff @(posedge clk_pixel_x5) begin
      if (reset) begin
         slot_p0      <= '0;
         hold_vld_p0  <= 1'b0;
         armed_p0     <= 1'b0;
         underflow_p0 <= 1'b0;
      end else begin
         slot_p0 <= last_slot ? '0 : slot_p0 + 1'b1;

         if (xfer)
            hold_vld_p0 <= 1'b1;
         else if (last_slot)
            hold_vld_p0 <= 1'b0;

         if (xfer)
            armed_p0 <= 1'b1;

         // a set in the same cycle as a clear must not be lost
         if (last_slot && !hold_vld_p0 && armed_p0)
            underflow_p0 <= 1'b1;
         else if (underflow_clear)
            underflow_p0 <= 1'b0;
      end
   end

   // hold data carries no reset; hold_vld_p0 qualifies it
   always_ff @(posedge clk_pixel_x5) begin
      if (xfer)
         hold_p0 <= in_data;
   end

   // p1: word-boundary strobe aligned with the lane output registers
   always_ff @(posedge clk_pixel_x5) begin
      if (reset)
         word_start_p1 <= 1'b0;
      else
         word_start_p1 <= (slot_p0 == '0);
   end

   assign out_word_start = word_start_p1;
   assign underflow      = underflow_p0;

   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_lane
      logic [WORD_WIDTH-1:0] load_word;

      assign load_word = hold_vld_p0 ? hold_p0[c*WORD_WIDTH +: WORD_WIDTH] : IDLE_WORD;

      serializer_lane #(
         .WORD_WIDTH     (WORD_WIDTH),
         .BITS_PER_CYCLE (BITS_PER_CYCLE),
         .RESET_WORD     (IDLE_WORD)
      ) u_lane (
         .clk_pixel_x5 (clk_pixel_x5),
         .reset        (reset),
         .load         (last_slot),
         .load_word    (load_word),
         .out_bits     (out_bits[c*BITS_PER_CYCLE +: BITS_PER_CYCLE])
      );
   end

`ifdef SERIALIZER_NCH_CLOCK_LANE_EN
   // lower half of the word high: one pixel-clock period per word
   localparam logic [WORD_WIDTH-1:0] CLOCK_WORD =
      {WORD_WIDTH{1'b1}} >> (WORD_WIDTH - WORD_WIDTH/2);

   serializer_lane #(
      .WORD_WIDTH     (WORD_WIDTH),
      .BITS_PER_CYCLE (BITS_PER_CYCLE),
      .RESET_WORD     (CLOCK_WORD)
   ) u_clock_lane (
      .clk_pixel_x5 (clk_pixel_x5),
      .reset        (reset),
      .load         (last_slot),
      .load_word    (CLOCK_WORD),
      .out_bits     (out_clock_bits)
   );
`endif

endmodule

// File: tb/tb_serializer_nch.sv
// Directed self-checking bench for serializer_nch (3 lanes, W=10, B=2).
module tb_serializer_nch;

   localparam int NCH = 3;
   localparam int W   = 10;
   localparam int B   = 2;
   localparam int SL  = 5;
   localparam logic [W-1:0] IDLE = 10'h354;

   logic             clk_pixel_x5 = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [NCH*W-1:0] in_data;
   logic [NCH*B-1:0] out_bits;
   logic             out_word_start;
   logic             underflow;
   logic             underflow_clear;
`ifdef SERIALIZER_NCH_CLOCK_LANE_EN
   logic [B-1:0]     out_clock_bits;
`endif

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always #5 clk_pixel_x5 = ~clk_pixel_x5;

   serializer_nch dut (
      .clk_pixel_x5    (clk_pixel_x5),
      .reset           (reset),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_data         (in_data),
      .out_bits        (out_bits),
      .out_word_start  (out_word_start),
`ifdef SERIALIZER_NCH_CLOCK_LANE_EN
      .out_clock_bits  (out_clock_bits),
`endif
      .underflow       (underflow),
      .underflow_clear (underflow_clear)
   );

   task automatic tick();
      @(posedge clk_pixel_x5);
      #1;
      cyc++;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      underflow_clear = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      cyc = 0;
   endtask

   function automatic logic [NCH*W-1:0] fill(input logic [W-1:0] w);
      return {NCH{w}};
   endfunction

   function automatic logic [NCH*B-1:0] slice_all(input logic [NCH*W-1:0] words, input int idx);
      logic [NCH*B-1:0] r;
      r = '0;
      for (int c = 0; c < NCH; c++)
         r[c*B +: B] = words[c*W + idx*B +: B];
      return r;
   endfunction

   function automatic logic [NCH*W-1:0] mkdata(input int k);
      logic [NCH*W-1:0] r;
      for (int c = 0; c < NCH; c++)
         r[c*W +: W] = W'(k*37 + c*101) ^ 10'h2C1;
      return r;
   endfunction

   task automatic test_reset();
      logic [NCH*B-1:0] exp_bits;
      logic             exp_ws;
      logic [W-1:0]     clk_word;
      reset = 1'b1;
      in_valid = 1'b0;
      underflow_clear = 1'b0;
      in_data = '0;
      tick();
      tick();
      checks++; if (out_bits !== '0) begin failures++; $display("FAIL reset_out_bits got=%h want=0", out_bits); end
      checks++; if (out_word_start !== 1'b0) begin failures++; $display("FAIL reset_word_start got=%b want=0", out_word_start); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL reset_underflow got=%b want=0", underflow); end
      reset = 1'b0;
      cyc = 0;
      clk_word = 10'h01F;
      for (int k = 1; k <= 15; k++) begin
         tick();
         exp_bits = slice_all(fill(IDLE), (k-1) % SL);
         exp_ws = ((k-1) % SL) == 0;
         checks++; if (out_bits !== exp_bits) begin failures++; $display("FAIL idle_bits k=%0d got=%h want=%h", k, out_bits, exp_bits); end
         checks++; if (out_word_start !== exp_ws) begin failures++; $display("FAIL idle_word_start k=%0d got=%b want=%b", k, out_word_start, exp_ws); end
         checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL idle_underflow k=%0d got=%b want=0", k, underflow); end
`ifdef SERIALIZER_NCH_CLOCK_LANE_EN
         checks++; if (out_clock_bits !== clk_word[((k-1) % SL)*B +: B]) begin failures++;
            $display("FAIL clock_lane k=%0d got=%b want=%b", k, out_clock_bits, clk_word[((k-1) % SL)*B +: B]); end
`endif
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0]     base [3];
      logic [NCH*W-1:0] wv [3];
      logic [NCH*B-1:0] exp_bits;
      logic [NCH*W-1:0] exp_word;
      logic             hv, xf, exp_rdy, exp_ws, exp_uf;
      int               j;
      base[0] = 10'h3FF; base[1] = 10'h000; base[2] = 10'h2AA;
      for (int w = 0; w < 3; w++)
         for (int c = 0; c < NCH; c++)
            wv[w][c*W +: W] = base[(w + c) % 3];
      apply_reset();
      j = 0;
      hv = 1'b0;
      in_valid = 1'b1;
      in_data = wv[0];
      for (int k = 1; k <= 25; k++) begin
         exp_rdy = !hv || (((k-1) % SL) == SL-1);
         checks++; if (in_ready !== exp_rdy) begin failures++; $display("FAIL b2b_in_ready k=%0d got=%b want=%b", k, in_ready, exp_rdy); end
         xf = in_valid && in_ready;
         tick();
         if (xf) hv = 1'b1;
         else if (((k-1) % SL) == SL-1) hv = 1'b0;
         if (xf) begin
            j++;
            if (j < 3) in_data = wv[j];
            else in_valid = 1'b0;
         end
         exp_word = (k >= 6 && k <= 20) ? wv[(k-6)/SL] : fill(IDLE);
         exp_bits = slice_all(exp_word, (k-1) % SL);
         exp_ws = ((k-1) % SL) == 0;
         exp_uf = (k >= 20);
         checks++; if (out_bits !== exp_bits) begin failures++; $display("FAIL b2b_bits k=%0d got=%h want=%h", k, out_bits, exp_bits); end
         checks++; if (out_word_start !== exp_ws) begin failures++; $display("FAIL b2b_word_start k=%0d got=%b want=%b", k, out_word_start, exp_ws); end
         checks++; if (underflow !== exp_uf) begin failures++; $display("FAIL b2b_underflow k=%0d got=%b want=%b", k, underflow, exp_uf); end
      end
      checks++; if (j !== 3) begin failures++; $display("FAIL b2b_transfers got=%0d want=3", j); end
   endtask

   task automatic test_underflow();
      logic [NCH*B-1:0] exp_bits;
      logic [NCH*W-1:0] exp_word;
      logic             exp_uf;
      apply_reset();
      in_valid = 1'b1;
      in_data = fill(10'h1F0);
      for (int k = 1; k <= 20; k++) begin
         underflow_clear = (k == 13 || k == 15 || k == 16);
         tick();
         if (k == 1) in_valid = 1'b0;
         exp_word = (k >= 6 && k <= 10) ? fill(10'h1F0) : fill(IDLE);
         exp_bits = slice_all(exp_word, (k-1) % SL);
         exp_uf = (k >= 10 && k <= 12) || (k == 15) || (k == 20);
         checks++; if (out_bits !== exp_bits) begin failures++; $display("FAIL uf_bits k=%0d got=%h want=%h", k, out_bits, exp_bits); end
         checks++; if (underflow !== exp_uf) begin failures++; $display("FAIL uf_flag k=%0d got=%b want=%b", k, underflow, exp_uf); end
      end
      underflow_clear = 1'b0;
   endtask

   task automatic test_stall();
      logic [NCH*B-1:0] exp_bits;
      logic [NCH*W-1:0] exp_word;
      logic             exp_rdy;
      apply_reset();
      in_valid = 1'b1;
      in_data = mkdata(0);
      for (int k = 1; k <= 15; k++) begin
         exp_rdy = (k == 1) || (((k-1) % SL) == SL-1);
         checks++; if (in_ready !== exp_rdy) begin failures++; $display("FAIL stall_in_ready k=%0d got=%b want=%b", k, in_ready, exp_rdy); end
         tick();
         in_data = mkdata(k);
         if (k >= 6 && k <= 10) exp_word = mkdata(0);
         else if (k >= 11) exp_word = mkdata(4);
         else exp_word = fill(IDLE);
         exp_bits = slice_all(exp_word, (k-1) % SL);
         checks++; if (out_bits !== exp_bits) begin failures++; $display("FAIL stall_bits k=%0d got=%h want=%h", k, out_bits, exp_bits); end
      end
      in_valid = 1'b0;
      checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL stall_underflow got=%b want=0", underflow); end
   endtask

   task automatic test_midword_reset();
      logic [NCH*B-1:0] exp_bits;
      logic [NCH*W-1:0] exp_word;
      logic             exp_ws, exp_uf;
      apply_reset();
      in_valid = 1'b1;
      in_data = fill(10'h3FF);
      for (int k = 1; k <= 7; k++) begin
         tick();
         if (k == 1) in_data = fill(10'h2AA);
         if (k == 5) in_valid = 1'b0;
      end
      exp_bits = slice_all(fill(10'h3FF), 1);
      checks++; if (out_bits !== exp_bits) begin failures++; $display("FAIL mid_pre_bits got=%h want=%h", out_bits, exp_bits); end
      reset = 1'b1;
      tick();
      checks++; if (out_bits !== '0) begin failures++; $display("FAIL mid_reset_bits got=%h want=0", out_bits); end
      checks++; if (out_word_start !== 1'b0) begin failures++; $display("FAIL mid_reset_word_start got=%b want=0", out_word_start); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_in_ready got=%b want=1", in_ready); end
      checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL mid_reset_underflow got=%b want=0", underflow); end
      reset = 1'b0;
      cyc = 0;
      in_valid = 1'b1;
      in_data = fill(10'h0AB);
      for (int k = 1; k <= 15; k++) begin
         tick();
         if (k == 1) in_valid = 1'b0;
         exp_word = (k >= 6 && k <= 10) ? fill(10'h0AB) : fill(IDLE);
         exp_bits = slice_all(exp_word, (k-1) % SL);
         exp_ws = ((k-1) % SL) == 0;
         exp_uf = (k >= 10);
         checks++; if (out_bits !== exp_bits) begin failures++; $display("FAIL mid_post_bits k=%0d got=%h want=%h", k, out_bits, exp_bits); end
         checks++; if (out_word_start !== exp_ws) begin failures++; $display("FAIL mid_post_word_start k=%0d got=%b want=%b", k, out_word_start, exp_ws); end
         checks++; if (underflow !== exp_uf) begin failures++; $display("FAIL mid_post_underflow k=%0d got=%b want=%b", k, underflow, exp_uf); end
      end
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      underflow_clear = 1'b0;
      test_reset();
      test_back_to_back();
      test_underflow();
      test_stall();
      test_midword_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
